// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch end of the PC path. Holds the byte-address PC and presents
// it to instruction memory as a word address (PC >> 1). It runs a read
// handshake and latches the returned word into IR. It also accepts byte-address
// jump targets and checks that they are word aligned.
//
// Ports:
//   CLK          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   fetch_req    control unit requests the next instruction
//   jump_en      load PC from jump_target
//   jump_target  byte-address jump target (bit 0 must be 0)
//   mem_rd       read request to instruction memory (held until mem_ready)
//   mem_addr     word address presented with mem_rd
//   mem_rdata    read data from memory, valid with mem_ready
//   mem_ready    memory data valid this cycle
//   IR           latched instruction
//   ir_valid     one-cycle pulse: IR has just been updated
//   PC           current byte-address PC
//   busy         high while a read is outstanding (REQ state)
//   align_fault  sticky fault: an odd jump target was seen; only reset clears it
//
// Timing: fetch_req sampled at edge k -> mem_rd high after k. mem_ready sampled
// at edge k+1 -> mem_rd/busy drop and PC updates after k+1. The returned word
// passes through a one-cycle capture register, so IR/ir_valid change after k+2.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                    PC_WIDTH    = 14,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic                   fetch_req,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic                   mem_rd,
  output logic [PC_WIDTH-2:0]    mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_ready,
  output logic [INSTR_WIDTH-1:0] IR,
  output logic                   ir_valid,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   busy,
  output logic                   align_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [PC_WIDTH-2:0]    mem_addr_q, mem_addr_d;
  logic                   busy_q, busy_d;
  logic                   fault_q, fault_d;

  // Jump seen while a read is outstanding; applied when the read completes.
  logic                   pend_q, pend_d;
  logic [PC_WIDTH-1:0]    pend_tgt_q, pend_tgt_d;

  // Capture stage for the returned word (IR updates one cycle after mem_ready).
  logic                   cap_q, cap_d;
  logic [INSTR_WIDTH-1:0] cap_data_q, cap_data_d;

  // A jump_en arriving in the completion cycle itself is the most recent one,
  // so it takes precedence over an earlier pending target.
  logic                   pend_eff;
  logic [PC_WIDTH-1:0]    pend_tgt_eff;

  assign pend_eff     = jump_en | pend_q;
  assign pend_tgt_eff = jump_en ? jump_target : pend_tgt_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (jump_en && jump_target[0]) state_d = FAULT;
        else if (fetch_req)            state_d = REQ;
      end
      REQ: begin
        if (mem_ready) state_d = (pend_eff && pend_tgt_eff[0]) ? FAULT : IDLE;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    ir_d       = cap_q ? cap_data_q : ir_q;
    ir_valid_d = cap_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    fault_d    = fault_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    cap_d      = 1'b0;
    cap_data_d = cap_data_q;

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (jump_en && jump_target[0]) begin
          // Odd target: PC untouched and any simultaneous fetch_req dropped.
          fault_d = 1'b1;
        end else begin
          if (jump_en) pc_d = jump_target;
          if (fetch_req) begin
            mem_rd_d   = 1'b1;
            busy_d     = 1'b1;
            // Jump first, then fetch from the new target in the same cycle.
            mem_addr_d = jump_en ? jump_target[PC_WIDTH-1:1] : pc_q[PC_WIDTH-1:1];
          end
        end
      end

      REQ: begin
        if (mem_ready) begin
          cap_d      = 1'b1;
          cap_data_d = mem_rdata;
          mem_rd_d   = 1'b0;
          busy_d     = 1'b0;
          pend_d     = 1'b0;
          if (pend_eff) begin
            if (pend_tgt_eff[0]) fault_d = 1'b1;
            else                 pc_d    = pend_tgt_eff;
          end else begin
            pc_d = pc_q + PC_WIDTH'(2);  // wraps modulo 2^PC_WIDTH
          end
        end else if (jump_en) begin
          // Last jump wins while the read is still outstanding.
          pend_d     = 1'b1;
          pend_tgt_d = jump_target;
        end
      end

      FAULT: begin
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
      end

      default: begin
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath registers. Reset abandons any outstanding read: mem_rd
  // falls asynchronously and the capture stage is cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      cap_q      <= 1'b0;
      cap_data_q <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      cap_q      <= cap_d;
      cap_data_q <= cap_data_d;
    end
  end

  assign PC          = pc_q;
  assign IR          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = busy_q;
  assign align_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. Stimulus tasks drive the control and
// memory sides and push the expected {IR, PC, cycle} of each completed fetch
// into a queue; an independent monitor pops and compares on every ir_valid.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam int PCW = 14;
  localparam int IW  = 16;

  logic           CLK = 1'b0;
  logic           Reset_n;
  logic           fetch_req;
  logic           jump_en;
  logic [PCW-1:0] jump_target;
  logic           mem_rd;
  logic [PCW-2:0] mem_addr;
  logic [IW-1:0]  mem_rdata;
  logic           mem_ready;
  logic [IW-1:0]  IR;
  logic           ir_valid;
  logic [PCW-1:0] PC;
  logic           busy;
  logic           align_fault;

  pc_fetch_unit #(
    .PC_WIDTH   (PCW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (14'h0000)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .fetch_req  (fetch_req),
    .jump_en    (jump_en),
    .jump_target(jump_target),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .PC         (PC),
    .busy       (busy),
    .align_fault(align_fault)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0]  ir;
    logic [PCW-1:0] pc;
    int             at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   n_pushed = 0;
  int   n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Scoreboard monitor: every ir_valid must match the oldest expectation.
  always @(negedge CLK) begin
    if (ir_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ir_valid: IR=%0h PC=%0h with nothing outstanding (t=%0t)",
                 IR, PC, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ir_data",    {16'h0, IR}, {16'h0, e.ir});
        check("pc_after",   {18'h0, PC}, {18'h0, e.pc});
        check("ir_latency", cyc,         e.at_cyc);
      end
    end
  end

  // One fetch from an IDLE unit. Optional jump with fetch_req (jmp/tgt), and an
  // optional jump in the first REQ cycle (mj/mj_tgt, needs waits >= 1).
  task automatic do_fetch(input logic jmp, input logic [PCW-1:0] tgt, input int waits,
                          input logic mj, input logic [PCW-1:0] mj_tgt,
                          input logic [IW-1:0] rdata, input logic [PCW-2:0] exp_addr,
                          input logic [PCW-1:0] exp_pc);
    exp_t e;
    fetch_req   = 1'b1;
    jump_en     = jmp;
    jump_target = tgt;
    @(negedge CLK);
    fetch_req = 1'b0;
    jump_en   = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("req_mem_rd",   mem_rd,   1);
      check("req_mem_addr", mem_addr, exp_addr);
      check("req_busy",     busy,     1);
      jump_en     = (i == 0) ? mj : 1'b0;
      jump_target = mj_tgt;
      @(negedge CLK);
    end
    jump_en = 1'b0;
    check("last_mem_rd",   mem_rd,   1);
    check("last_mem_addr", mem_addr, exp_addr);
    check("last_busy",     busy,     1);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    e.ir = rdata; e.pc = exp_pc; e.at_cyc = cyc + 2;
    exp_q.push_back(e);
    n_pushed++;
    @(negedge CLK);
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    check("done_mem_rd", mem_rd, 0);
    check("done_busy",   busy,   0);
    @(negedge CLK);   // ir_valid visible here
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; fetch_req = 1'b0; jump_en = 1'b0; jump_target = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    @(negedge CLK); @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_pc",       PC,          0);
    check("rst_ir",       IR,          0);
    check("rst_mem_rd",   mem_rd,      0);
    check("rst_mem_addr", mem_addr,    0);
    check("rst_ir_valid", ir_valid,    0);
    check("rst_busy",     busy,        0);
    check("rst_fault",    align_fault, 0);

    // Zero-wait fetch from PC 0
    do_fetch(0, '0, 0, 0, '0, 16'hA5C3, 13'h0000, 14'h0002);
    // Three wait cycles: mem_rd held four cycles
    do_fetch(0, '0, 3, 0, '0, 16'h0F0F, 13'h0001, 14'h0004);

    // PC wrap: jump to 3FFE, then fetch
    jump_en = 1'b1; jump_target = 14'h3FFE;
    @(negedge CLK);
    jump_en = 1'b0;
    check("jump_idle_pc", PC, 14'h3FFE);
    do_fetch(0, '0, 0, 0, '0, 16'h1234, 13'h1FFF, 14'h0000);

    // Jump+fetch together, then overriding jump while in REQ
    do_fetch(1, 14'h0124, 2, 1, 14'h0200, 16'h5A5A, 13'h0092, 14'h0200);

    // mem_ready outside REQ is ignored
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge CLK);
    mem_ready = 1'b0;
    @(negedge CLK);
    check("idle_ready_ir", IR,   16'h5A5A);
    check("idle_ready_pc", PC,   14'h0200);
    check("idle_ready_rd", mem_rd, 0);

    // Odd jump in IDLE with fetch_req: fault, PC unchanged, fetch dropped
    jump_en = 1'b1; jump_target = 14'h0011; fetch_req = 1'b1;
    @(negedge CLK);
    jump_en = 1'b0; fetch_req = 1'b0;
    check("odd_fault",  align_fault, 1);
    check("odd_pc",     PC,          14'h0200);
    check("odd_mem_rd", mem_rd,      0);
    check("odd_busy",   busy,        0);
    fetch_req = 1'b1;
    @(negedge CLK);
    fetch_req = 1'b0;
    @(negedge CLK);
    check("fault_fetch_rd",   mem_rd, 0);
    check("fault_fetch_busy", busy,   0);
    check("fault_sticky",     align_fault, 1);
    Reset_n = 1'b0;
    #1;
    check("rst_clr_fault", align_fault, 0);
    check("rst_clr_pc",    PC,          0);
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);

    // Reset mid-REQ: mem_rd drops immediately, no ir_valid
    fetch_req = 1'b1;
    @(negedge CLK);
    fetch_req = 1'b0;
    check("midreq_rd_before", mem_rd, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("midreq_rd_async", mem_rd, 0);
    check("midreq_busy",     busy,   0);
    @(negedge CLK); @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    check("midreq_pc",   PC,     0);
    check("midreq_idle", mem_rd, 0);
    do_fetch(0, '0, 1, 0, '0, 16'hC0DE, 13'h0000, 14'h0002);

    // Odd pending jump during REQ: IR still delivered, then fault
    do_fetch(0, '0, 1, 1, 14'h0033, 16'hBEEF, 13'h0001, 14'h0002);
    check("pend_odd_fault", align_fault, 1);

    repeat (3) @(negedge CLK);
    check("pulse_count",  n_pulses,       n_pushed);
    check("queue_drained", exp_q.size(),  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
